// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential 2-bit-digit multiplier.
//   state_t  : controller states IDLE / RUN / DONE
//   DIGIT_W  : width of one operand digit fed to the 2x2 multiplier cell
package mul_seq_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier_2bit.sv
// 2x2 unsigned multiplier cell (purely combinational).
// Ports:
//   a [1:0] : unsigned digit
//   b [1:0] : unsigned digit
//   p [3:0] : a*b, at most 9, never truncated
module multiplier_2bit
  import mul_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0]   a,
  input  logic [DIGIT_W-1:0]   b,
  output logic [2*DIGIT_W-1:0] p
);

  assign p = {{DIGIT_W{1'b0}}, a} * {{DIGIT_W{1'b0}}, b};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier: walks every pair of 2-bit digits of the
// latched operands, one pair per clock, accumulating the shifted 2x2 partial
// products into a 2*WIDTH-bit accumulator.
//
// Parameters:
//   WIDTH : operand width, even and >= 4
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : request a multiply (sampled only in IDLE, with a and b)
//   a, b  : unsigned operands
//   busy  : high while in RUN
//   done  : one-cycle pulse when p holds a new product
//   p     : registered product, held until replaced by the next result
//
// Build option:
//   MUL_SEQ_SKIP_ZERO_EN : when defined, an all-zero digit of a is skipped in
//                          one cycle instead of walking all digits of b.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      p_q, p_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;

  logic [DIGIT_W-1:0]   a_dig;
  logic [DIGIT_W-1:0]   b_dig;
  logic [2*DIGIT_W-1:0] pp;
  logic [IDX_W+1:0]     shamt;
  logic [PW-1:0]        pp_sh;
  logic                 skip;

  // Digit selects: digit k occupies bits [2k+1:2k].
  assign a_dig = a_q[{i_q, 1'b0} +: DIGIT_W];
  assign b_dig = b_q[{j_q, 1'b0} +: DIGIT_W];

  multiplier_2bit u_mul2 (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  // Weight of the digit pair is 4^(i+j), i.e. a shift of 2*(i+j).
  assign shamt = ({2'b00, i_q} + {2'b00, j_q}) << 1;
  assign pp_sh = PW'(pp) << shamt;

`ifdef MUL_SEQ_SKIP_ZERO_EN
  // Only decided at the start of a row so a row is either fully walked or
  // skipped as a whole.
  assign skip = (j_q == '0) && (a_dig == '0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (skip) begin
          if (i_q == LAST) begin
            p_d     = acc_q;
            state_d = DONE;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end else begin
          // Sum of all shifted partials equals a*b < 2^PW, so no wrap.
          acc_d = acc_q + pp_sh;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              p_d     = acc_q + pp_sh;
              state_d = DONE;
            end else begin
              i_d = i_q + IDX_W'(1);
            end
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Operand holding registers need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule
